// File: rtl/morse_symbol_sequencer.sv
// morse_symbol_sequencer: turns keyed mark/space durations, timed by an external BCD unit counter, into DOT/DASH/gap symbols.
// Optional MORSE_SEQ_TIMEOUT_EN: a space reaching max_units emits WORD_GAP and returns to IDLE.
`ifndef UNIT_BCD_W
`define UNIT_BCD_W 2
`endif
module morse_symbol_sequencer (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       ce,
  input  logic                       signal,
  input  logic [`UNIT_BCD_W*4-1:0]   pulses_per_unit,
  input  logic [`UNIT_BCD_W*4-1:0]   max_units,
  input  logic [`UNIT_BCD_W*4-1:0]   units_cnt,
  output logic                       units_clr,
  output logic                       units_ce,
  output logic                       sym_valid,
  output logic [1:0]                 sym_code,
  input  logic                       sym_ready,
  output logic                       overrun
);
  localparam int W = `UNIT_BCD_W;
  localparam int BW = 4 * W;
  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;
  state_t state, nxt;
  logic last_signal, rise, fall, tick, new_sym, leave;
  logic [1:0] code;
  logic [BW-1:0] presc, presc_inc, ppu;
  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
    logic c;
    c = 1'b1;
    bcd_inc = v;
    for (int i = 0; i < W; i++)
      if (c) begin
        c = v[4*i+:4] == 4'd9;
        bcd_inc[4*i+:4] = c ? 4'd0 : v[4*i+:4] + 4'd1;
      end
  endfunction
  assign ppu = pulses_per_unit == '0 ? BW'(1) : pulses_per_unit;
  assign presc_inc = bcd_inc(presc);
  // >= rather than == so a ppu lowered mid-count still wraps promptly
  assign tick = presc_inc >= ppu;
  assign rise = ce & signal & ~last_signal;
  assign fall = ce & ~signal & last_signal;
  assign units_ce = ce & tick & (units_cnt != max_units) & (state != IDLE);
  always_comb begin
    nxt = state;
    new_sym = 1'b0;
    code = 2'd0;
    leave = 1'b0;
    case (state)
      IDLE: nxt = rise ? MARK : IDLE;
      MARK:
        if (fall) begin
          nxt = SPACE;
          leave = 1'b1;
          new_sym = 1'b1;
          code = units_cnt < BW'(2) ? 2'd0 : 2'd1;
        end
      SPACE:
        if (rise) begin
          nxt = MARK;
          leave = 1'b1;
          new_sym = units_cnt >= BW'(2);
          code = units_cnt >= BW'(5) ? 2'd3 : 2'd2;
        end
`ifdef MORSE_SEQ_TIMEOUT_EN
        else if (ce && units_cnt == max_units) begin
          nxt = IDLE;
          leave = 1'b1;
          new_sym = 1'b1;
          code = 2'd3;
        end
`endif
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      last_signal <= 1'b0;
      presc <= '0;
      sym_valid <= 1'b0;
      sym_code <= 2'd0;
      overrun <= 1'b0;
      units_clr <= 1'b1;
    end else begin
      state <= nxt;
      units_clr <= nxt == IDLE || leave;
      if (ce) begin
        last_signal <= signal;
        presc <= (rise || fall || tick) ? '0 : presc_inc;
      end
      if (new_sym && (!sym_valid || sym_ready)) begin
        sym_valid <= 1'b1;
        sym_code <= code;
      end else if (sym_ready) sym_valid <= 1'b0;
      if (new_sym && sym_valid && !sym_ready) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// tb_morse_symbol_sequencer: scoreboard bench with an external BCD unit counter and a duration-based symbol model.
`ifndef UNIT_BCD_W
`define UNIT_BCD_W 2
`endif
module tb_morse_symbol_sequencer;
  localparam int BW = 4 * `UNIT_BCD_W;
  logic clk = 1'b0, clr = 1'b1, ce = 1'b0, signal = 1'b0, sym_ready = 1'b1;
  logic [BW-1:0] pulses_per_unit, max_units, units_cnt;
  logic units_clr, units_ce, sym_valid, overrun;
  logic [1:0] sym_code;
  int cnt = 0, ppu_int = 5, max_int = 9, checks = 0, errors = 0;
  int q[$];

  always #5 clk = ~clk;

  morse_symbol_sequencer dut (
    .clk(clk), .clr(clr), .ce(ce), .signal(signal),
    .pulses_per_unit(pulses_per_unit), .max_units(max_units), .units_cnt(units_cnt),
    .units_clr(units_clr), .units_ce(units_ce), .sym_valid(sym_valid),
    .sym_code(sym_code), .sym_ready(sym_ready), .overrun(overrun)
  );

  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < BW / 4; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // external unit counter driven by the DUT
  assign units_cnt = to_bcd(cnt);
  always @(posedge clk)
    if (units_clr) cnt <= 0;
    else if (units_ce) cnt <= cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // monitor: a handshake seen here completes at the following posedge
  always @(negedge clk) begin
    if (units_ce) check("no_saturation_overshoot", int'(cnt < max_int), 1);
    if (!clr && sym_valid && sym_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_symbol: got code %0d, required none", sym_code);
      end else check("sym_code", int'(sym_code), q.pop_front());
    end
  end

  function automatic int units(input int n);
    int c;
    c = (n - 1) / ppu_int;
    return c > max_int ? max_int : c;
  endfunction

  function automatic int mark_sym(input int n);
    return units(n) < 2 ? 0 : 1;
  endfunction

  function automatic int space_sym(input int n);
    int u;
    u = units(n);
    return u < 2 ? -1 : (u < 5 ? 2 : 3);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int p, input int m);
    ppu_int = p;
    max_int = m;
    pulses_per_unit = to_bcd(p);
    max_units = to_bcd(m);
  endtask

  task automatic chk_reset();
    check("rst_sym_valid", int'(sym_valid), 0);
    check("rst_sym_code", int'(sym_code), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_units_ce", int'(units_ce), 0);
    check("rst_units_clr", int'(units_clr), 1);
  endtask

  task automatic do_clr();
    cyc();
    clr = 1'b1;
    ce = 1'b0;
    signal = 1'b0;
    cyc();
    clr = 1'b0;
  endtask

  // one keyed element lasting n ce cycles, with up to gap idle clocks before each
  task automatic elem(input logic lvl, input int n, input int gap, input bit chk);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap, 0)) begin
        cyc();
        ce = 1'b0;
        signal = lvl;
      end
      cyc();
      if (chk && i == 1) check("units_clr_pulse", int'(units_clr), 1);
      if (chk && i == 2) check("units_clr_release", int'(units_clr), 0);
      signal = lvl;
      ce = 1'b1;
    end
  endtask

  task automatic drain(input string name);
    cyc();
    ce = 1'b0;
    repeat (5) cyc();
    check(name, q.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s, nm;
    cfg(5, 9);
    do_clr();
    chk_reset();
    q.push_back(0); q.push_back(1);
    elem(1'b1, 5, 0, 1'b0); elem(1'b0, 5, 0, 1'b1); elem(1'b1, 15, 0, 1'b1); elem(1'b0, 3, 0, 1'b1);
    drain("dot_dash_done");
    do_clr();
    q.push_back(0); q.push_back(2); q.push_back(0);
    elem(1'b1, 5, 0, 1'b0); elem(1'b0, 15, 0, 1'b1); elem(1'b1, 5, 0, 1'b1); elem(1'b0, 3, 0, 1'b1);
    drain("letter_gap_done");
    do_clr();
    q.push_back(0); q.push_back(3); q.push_back(0);
    elem(1'b1, 5, 0, 1'b0); elem(1'b0, 100, 0, 1'b1);
`ifdef MORSE_SEQ_TIMEOUT_EN
    check("timeout_idle_clr", int'(units_clr), 1);
    check("timeout_cnt", cnt, 0);
`else
    check("long_space_clr", int'(units_clr), 0);
    check("long_space_cnt", cnt, 9);
`endif
    elem(1'b1, 5, 0, 1'b0); elem(1'b0, 3, 0, 1'b0);
    drain("word_gap_done");
    do_clr();
    sym_ready = 1'b0;
    q.push_back(0);
    elem(1'b1, 5, 0, 1'b0); elem(1'b0, 5, 0, 1'b1); elem(1'b1, 15, 0, 1'b1); elem(1'b0, 3, 0, 1'b1);
    cyc();
    ce = 1'b0;
    cyc();
    check("held_valid", int'(sym_valid), 1);
    check("held_code", int'(sym_code), 0);
    check("overrun_set", int'(overrun), 1);
    sym_ready = 1'b1;
    cyc();
    check("consumed_valid", int'(sym_valid), 0);
    check("overrun_sticky", int'(overrun), 1);
    check("overrun_queue", q.size(), 0);
    do_clr();
    elem(1'b1, 8, 0, 1'b0);
    cyc();
    clr = 1'b1;
    signal = 1'b0;
    ce = 1'b1;
    cyc();
    chk_reset();
    clr = 1'b0;
    repeat (20) cyc();
    check("mid_mark_clr_no_sym", int'(sym_valid), 0);
    ce = 1'b0;
    for (int r = 0; r < 6; r++) begin
      do_clr();
      cfg($urandom_range(9, 2), $urandom_range(15, 5));
      nm = $urandom_range(6, 3);
      for (int j = 0; j < nm; j++) begin
        n = $urandom_range(12 * ppu_int, 1);
        q.push_back(mark_sym(n));
        elem(1'b1, n, 2, 1'b0);
        if (j < nm - 1) begin
          n = $urandom_range(8 * ppu_int, 1);
          s = space_sym(n);
          if (s >= 0) q.push_back(s);
          elem(1'b0, n, 2, 1'b0);
        end
      end
      elem(1'b0, 2, 0, 1'b0);
      drain("random_round_done");
      check("random_no_overrun", int'(overrun), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/morse_symbol_sequencer.md
MORSE_SYMBOL_SEQUENCER -- requirements
Module: morse_symbol_sequencer

Interface
REQ-001 SHALL have parameter-free ports; widths use `UNIT_BCD_W from defines.vh; all BCD buses are UNIT_BCD_W*4 bits.
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 clr  in  1  reset, synchronous, active-high.
REQ-004 ce  in  1  clock enable; state, prescaler and edge detect advance only when ce=1.
REQ-005 signal  in  1  keyed Morse level (pre-synchronized), 1=mark.
REQ-006 pulses_per_unit  in  UNIT_BCD_W*4  BCD ce-pulses per time unit; value 0 treated as 1.
REQ-007 max_units  in  UNIT_BCD_W*4  BCD saturation limit of the unit counter.
REQ-008 units_cnt  in  UNIT_BCD_W*4  BCD count from external unit counter.
REQ-009 units_clr  out  1  synchronous clear to external unit counter.
REQ-010 units_ce  out  1  increment enable to external unit counter.
REQ-011 sym_valid  out  1  output symbol present.
REQ-012 sym_code  out  2  0=DOT, 1=DASH, 2=LETTER_GAP, 3=WORD_GAP.
REQ-013 sym_ready  in  1  consumer accepts symbol when sym_valid&sym_ready.
REQ-014 overrun  out  1  sticky: symbol dropped because output register full.

Function
REQ-015 States: IDLE, MARK, SPACE; edge detect compares signal with last_signal, last_signal updated on every ce cycle.
REQ-016 Prescaler: BCD counter 0..pulses_per_unit-1 on ce; tick on terminal value; restarts at 0 on every detected edge.
REQ-017 units_ce = ce & tick & (units_cnt != max_units); counter never passes max_units.
REQ-018 IDLE: units_clr=1 constantly; rising edge -> MARK.
REQ-019 MARK: falling edge -> classify units_cnt: <2 DOT, >=2 DASH; -> SPACE.
REQ-020 SPACE: rising edge -> classify units_cnt: <2 no symbol, 2..4 LETTER_GAP, >=5 WORD_GAP; -> MARK.
REQ-021 On every edge leaving MARK or SPACE, units_clr SHALL pulse high for exactly one clk cycle, registered (cycle after edge ce).
REQ-022 Symbol latency: sym_valid/sym_code registered, high one clk after the ce cycle detecting the edge.
REQ-023 sym_valid/sym_code hold until accepted; sym_valid falls the cycle after sym_valid&sym_ready.
REQ-024 New symbol while valid and not accepted in same cycle: new symbol dropped, old held, overrun set.
REQ-025 New symbol same cycle as acceptance: new symbol loaded, sym_valid stays 1, no overrun.
REQ-026 BCD comparisons digit-wise most-significant first; invalid BCD digits undefined behaviour.
REQ-027 ce=0: no state, prescaler, last_signal or symbol-generation change; handshake acceptance still works.

Reset
REQ-028 clr=1 at posedge: state IDLE, last_signal 0, prescaler 0, sym_valid 0, sym_code 0, overrun 0, units_ce 0, units_clr 1.
REQ-029 clr mid-MARK/SPACE or with pending symbol: pending symbol discarded, no symbol emitted for interrupted element.
REQ-030 clr has priority over ce and sym_ready.

Configuration
REQ-031 Macro MORSE_SEQ_TIMEOUT_EN defined: in SPACE, when units_cnt == max_units, emit WORD_GAP once (REQ-024/025 rules), pulse units_clr, -> IDLE; subsequent rising edge emits no gap.
REQ-032 Macro undefined: SPACE waits indefinitely at saturated count; gap classified only on next rising edge.

Verification
REQ-033 ppu=5, max=9; mark 5 ce then space 5 ce then mark 15 ce, sym_ready=1 -> DOT then DASH, no gap symbol.
REQ-034 ppu=5; mark 5, space 15, mark 5 -> DOT, LETTER_GAP, DOT; units_clr one-cycle pulse after each edge.
REQ-035 ppu=5, max=9, macro off; mark 5, space 100 ce, mark 5 -> DOT, WORD_GAP, DOT; units_cnt never exceeds 9.
REQ-036 Same stimulus, MORSE_SEQ_TIMEOUT_EN on -> WORD_GAP emitted when units_cnt reaches 9, state IDLE before next mark.
REQ-037 sym_ready=0; DOT then DASH -> sym_code=0 held, overrun=1; assert sym_ready -> DOT consumed, sym_valid=0.
REQ-038 clr pulsed mid-MARK after 8 ce -> all outputs at reset values next cycle, no symbol for that mark.
